// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: merges NCH sram-like masters onto one shared memory port.
// Address phase is round-robin arbitrated. A request that is presented but not
// yet accepted locks the grant until it is accepted. Responses come back in
// order and are steered to their owner by a FIFO of channel IDs.
module sram_like_arbiter #(
    parameter int NCH    = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    localparam int STRB_W = DATA_W / 8,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [NCH-1:0]          ch_req,
    input  logic [NCH-1:0]          ch_wr,
    input  logic [NCH*STRB_W-1:0]   ch_wstrb,
    input  logic [NCH*ADDR_W-1:0]   ch_addr,
    input  logic [NCH*DATA_W-1:0]   ch_wdata,
    output logic [NCH-1:0]          ch_addr_ok,
    output logic [NCH-1:0]          ch_data_ok,
    output logic [DATA_W-1:0]       ch_rdata,
    output logic                    mem_req,
    output logic                    mem_wr,
    output logic [STRB_W-1:0]       mem_wstrb,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [DATA_W-1:0]       mem_wdata,
    input  logic                    mem_addr_ok,
    input  logic                    mem_data_ok,
    input  logic [DATA_W-1:0]       mem_rdata,
    output logic [CNT_W-1:0]        outstanding,
    output logic                    err
);

    localparam int IDW   = $clog2(NCH);
    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_e;

    lock_state_e      state_q;
    logic [IDW-1:0]   lock_id_q;
    logic [IDW-1:0]   rr_q;
    logic             err_q;
    logic [IDW-1:0]   fifo_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    logic [IDW-1:0]   rr_pick_s;
    logic [IDW-1:0]   grant_s;
    logic [IDW-1:0]   head_s;
    logic             lock_hold_s;
    logic             lock_drop_s;
    logic             full_s;
    logic             xfer_s;
    logic             pop_s;
    logic             spur_s;

    // Round-robin search for the first requester after the last accepted channel.
    always_comb begin
        logic           found_v;
        logic [IDW:0]   sum_v;
        logic [IDW-1:0] idx_v;
        found_v   = 1'b0;
        rr_pick_s = rr_q;
        for (int i = 1; i <= NCH; i++) begin
            sum_v     = {1'b0, rr_q} + (IDW+1)'(i);
            idx_v     = (sum_v >= (IDW+1)'(NCH)) ? IDW'(sum_v - (IDW+1)'(NCH)) : sum_v[IDW-1:0];
            rr_pick_s = (!found_v && ch_req[idx_v]) ? idx_v : rr_pick_s;
            found_v   = found_v | ch_req[idx_v];
        end
    end

    // A pending lock wins only while its owner keeps requesting; dropping it is an error.
    assign lock_hold_s = (state_q == LOCKED) & ch_req[lock_id_q];
    assign lock_drop_s = (state_q == LOCKED) & ~ch_req[lock_id_q];
    assign grant_s     = lock_hold_s ? lock_id_q : rr_pick_s;

    // No bypass: a full FIFO blocks the request even if a pop happens this cycle.
    assign full_s  = (count_q == CNT_W'(DEPTH));
    assign mem_req = (|ch_req) & ~full_s;
    assign xfer_s  = mem_req & mem_addr_ok;

    assign head_s = fifo_q[rd_ptr_q];
    assign pop_s  = mem_data_ok & (count_q != '0);
    assign spur_s = mem_data_ok & (count_q == '0);

    assign ch_rdata    = pop_s ? mem_rdata : '0;
    assign outstanding = count_q;
    assign err         = err_q;

    // Steer the granted channel's fields onto the shared port and decode per-channel strobes.
    always_comb begin
        mem_wr     = 1'b0;
        mem_wstrb  = '0;
        mem_addr   = '0;
        mem_wdata  = '0;
        ch_addr_ok = '0;
        ch_data_ok = '0;
        for (int c = 0; c < NCH; c++) begin
            mem_wr        = (grant_s == IDW'(c)) ? ch_wr[c] : mem_wr;
            mem_wstrb     = (grant_s == IDW'(c)) ? ch_wstrb[c*STRB_W +: STRB_W] : mem_wstrb;
            mem_addr      = (grant_s == IDW'(c)) ? ch_addr[c*ADDR_W +: ADDR_W] : mem_addr;
            mem_wdata     = (grant_s == IDW'(c)) ? ch_wdata[c*DATA_W +: DATA_W] : mem_wdata;
            ch_addr_ok[c] = xfer_s & (grant_s == IDW'(c));
            ch_data_ok[c] = pop_s & (head_s == IDW'(c));
        end
    end

    // Next occupancy: a simultaneous push and pop leaves it unchanged.
    always_comb begin
        case ({xfer_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Lock FSM, round-robin pointer and sticky error flag.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= UNLOCKED;
            lock_id_q <= '0;
            rr_q      <= IDW'(NCH - 1);
            err_q     <= 1'b0;
        end else begin
            if (xfer_s) begin
                rr_q <= grant_s;
            end
            if (lock_drop_s || spur_s) begin
                err_q <= 1'b1;
            end
            case (state_q)
                UNLOCKED: begin
                    if (mem_req && !mem_addr_ok) begin
                        state_q   <= LOCKED;
                        lock_id_q <= grant_s;
                    end
                end
                LOCKED: begin
                    if (lock_drop_s) begin
                        if (mem_req && !mem_addr_ok) begin
                            lock_id_q <= grant_s;
                        end else begin
                            state_q <= UNLOCKED;
                        end
                    end else if (xfer_s) begin
                        state_q <= UNLOCKED;
                    end
                end
                default: state_q <= UNLOCKED;
            endcase
        end
    end

    // Response-order FIFO of channel IDs; pointers wrap modulo DEPTH.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < DEPTH; k++) begin
                fifo_q[k] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (xfer_s) begin
                fifo_q[wr_ptr_q] <= grant_s;
                wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Self-checking bench for sram_like_arbiter (NCH=2, DEPTH=4, 32-bit).
// Expected response owners are queued when an address phase is expected to be
// accepted and popped when the bench returns mem_data_ok.
module tb_sram_like_arbiter;

    localparam int NCH   = 2;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int SW    = DW / 8;
    localparam int CW    = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              resetn;
    logic [NCH-1:0]    ch_req;
    logic [NCH-1:0]    ch_wr;
    logic [NCH*SW-1:0] ch_wstrb;
    logic [NCH*AW-1:0] ch_addr;
    logic [NCH*DW-1:0] ch_wdata;
    logic [NCH-1:0]    ch_addr_ok;
    logic [NCH-1:0]    ch_data_ok;
    logic [DW-1:0]     ch_rdata;
    logic              mem_req;
    logic              mem_wr;
    logic [SW-1:0]     mem_wstrb;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic              mem_addr_ok;
    logic              mem_data_ok;
    logic [DW-1:0]     mem_rdata;
    logic [CW-1:0]     outstanding;
    logic              err;

    int checks = 0;
    int errors = 0;
    int exp_ch_q[$];

    always #5 clk = ~clk;

    sram_like_arbiter #(.NCH(NCH), .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn),
        .ch_req(ch_req), .ch_wr(ch_wr), .ch_wstrb(ch_wstrb), .ch_addr(ch_addr), .ch_wdata(ch_wdata),
        .ch_addr_ok(ch_addr_ok), .ch_data_ok(ch_data_ok), .ch_rdata(ch_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
        .mem_rdata(mem_rdata), .outstanding(outstanding), .err(err)
    );

    // Watchdog: the sequence is fixed-length, so this only fires on a hang.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ch_req      = '0;
        ch_wr       = '0;
        ch_wstrb    = '0;
        ch_addr     = '0;
        ch_wdata    = '0;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
        mem_rdata   = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        resetn = 1'b0;
        step();
        step();
        @(negedge clk);
        resetn = 1'b1;
        exp_ch_q.delete();
        step();
    endtask

    function automatic logic [1:0] onehot_of(input int ch);
        logic [1:0] v;
        v = 2'b11;
        if (ch == 0) v = 2'b01;
        if (ch == 1) v = 2'b10;
        return v;
    endfunction

    task automatic test_reset();
        idle_inputs();
        resetn = 1'b0;
        step();
        @(negedge clk);
        checks++;
        if ({mem_req, ch_addr_ok, ch_data_ok, outstanding, err} !== '0 || ch_rdata !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got req=%0b aok=%b dok=%b outst=%0d err=%0b rdata=%h want all zero",
                     mem_req, ch_addr_ok, ch_data_ok, outstanding, err, ch_rdata);
        end
        resetn = 1'b1;
        step();
    endtask

    task automatic test_single_read();
        int exp;
        ch_req = 2'b01;
        ch_addr[31:0] = 32'h0000_1000;
        mem_addr_ok = 1'b1;
        @(negedge clk);
        checks++;
        if (ch_addr_ok !== 2'b01 || mem_req !== 1'b1 || mem_addr !== 32'h0000_1000 || mem_wr !== 1'b0 || outstanding !== 3'd0) begin
            errors++;
            $display("FAIL single_addr: got aok=%b req=%0b addr=%h wr=%0b outst=%0d want aok=01 req=1 addr=00001000 wr=0 outst=0",
                     ch_addr_ok, mem_req, mem_addr, mem_wr, outstanding);
        end
        exp_ch_q.push_back(0);
        step();
        ch_req = 2'b00;
        mem_addr_ok = 1'b0;
        @(negedge clk);
        checks++;
        if (outstanding !== 3'd1 || ch_data_ok !== 2'b00) begin
            errors++;
            $display("FAIL single_pending: got outst=%0d dok=%b want outst=1 dok=00", outstanding, ch_data_ok);
        end
        step();
        mem_data_ok = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        exp = (exp_ch_q.size() > 0) ? exp_ch_q.pop_front() : -1;
        checks++;
        if (ch_data_ok !== onehot_of(exp) || ch_rdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL single_resp: got dok=%b rdata=%h want dok=%b rdata=deadbeef", ch_data_ok, ch_rdata, onehot_of(exp));
        end
        step();
        mem_data_ok = 1'b0;
        @(negedge clk);
        checks++;
        if (outstanding !== 3'd0) begin
            errors++;
            $display("FAIL single_drain: got outst=%0d want 0", outstanding);
        end
    endtask

    task automatic test_round_robin();
        int exp;
        logic [31:0] want_addr;
        do_reset();
        ch_addr = {32'h0000_3000, 32'h0000_1100};
        ch_req = 2'b11;
        mem_addr_ok = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            want_addr = ((k % 2) == 1) ? 32'h0000_3000 : 32'h0000_1100;
            checks++;
            if (ch_addr_ok !== onehot_of(k % 2) || mem_addr !== want_addr) begin
                errors++;
                $display("FAIL rr_grant%0d: got aok=%b addr=%h want aok=%b addr=%h",
                         k, ch_addr_ok, mem_addr, onehot_of(k % 2), want_addr);
            end
            exp_ch_q.push_back(k % 2);
            step();
        end
        ch_req = 2'b00;
        mem_addr_ok = 1'b0;
        @(negedge clk);
        checks++;
        if (outstanding !== 3'd4) begin
            errors++;
            $display("FAIL rr_outstanding: got %0d want 4", outstanding);
        end
        for (int k = 0; k < 4; k++) begin
            step();
            mem_data_ok = 1'b1;
            mem_rdata = 32'hC0DE_0000 + 32'(k);
            @(negedge clk);
            exp = (exp_ch_q.size() > 0) ? exp_ch_q.pop_front() : -1;
            checks++;
            if (ch_data_ok !== onehot_of(exp) || ch_rdata !== 32'hC0DE_0000 + 32'(k)) begin
                errors++;
                $display("FAIL rr_resp%0d: got dok=%b rdata=%h want dok=%b rdata=%h",
                         k, ch_data_ok, ch_rdata, onehot_of(exp), 32'hC0DE_0000 + 32'(k));
            end
        end
        step();
        mem_data_ok = 1'b0;
    endtask

    task automatic test_lock();
        int exp;
        ch_addr = {32'h0000_2000, 32'h0000_1004};
        ch_wr = 2'b10;
        ch_wstrb = 8'hF0;
        ch_wdata = {32'h1234_5678, 32'h0};
        ch_req = 2'b10;
        mem_addr_ok = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (mem_req !== 1'b1 || mem_addr !== 32'h0000_2000 || mem_wr !== 1'b1 || mem_wstrb !== 4'hF || ch_addr_ok !== 2'b00) begin
                errors++;
                $display("FAIL lock_hold%0d: got req=%0b addr=%h wr=%0b strb=%h aok=%b want req=1 addr=00002000 wr=1 strb=f aok=00",
                         k, mem_req, mem_addr, mem_wr, mem_wstrb, ch_addr_ok);
            end
            step();
            ch_req = 2'b11;
        end
        mem_addr_ok = 1'b1;
        @(negedge clk);
        checks++;
        if (ch_addr_ok !== 2'b10 || mem_wdata !== 32'h1234_5678) begin
            errors++;
            $display("FAIL lock_accept: got aok=%b wdata=%h want aok=10 wdata=12345678", ch_addr_ok, mem_wdata);
        end
        exp_ch_q.push_back(1);
        step();
        ch_req = 2'b01;
        ch_wr = 2'b00;
        @(negedge clk);
        checks++;
        if (ch_addr_ok !== 2'b01 || mem_addr !== 32'h0000_1004) begin
            errors++;
            $display("FAIL lock_next: got aok=%b addr=%h want aok=01 addr=00001004", ch_addr_ok, mem_addr);
        end
        exp_ch_q.push_back(0);
        step();
        ch_req = 2'b00;
        mem_addr_ok = 1'b0;
        for (int k = 0; k < 2; k++) begin
            mem_data_ok = 1'b1;
            mem_rdata = 32'hABCD_0000 + 32'(k);
            @(negedge clk);
            exp = (exp_ch_q.size() > 0) ? exp_ch_q.pop_front() : -1;
            checks++;
            if (ch_data_ok !== onehot_of(exp) || ch_rdata !== 32'hABCD_0000 + 32'(k)) begin
                errors++;
                $display("FAIL lock_resp%0d: got dok=%b rdata=%h want dok=%b", k, ch_data_ok, ch_rdata, onehot_of(exp));
            end
            step();
        end
        mem_data_ok = 1'b0;
    endtask

    task automatic test_full_and_back_to_back();
        int exp;
        ch_addr = {32'h0, 32'h0000_4000};
        ch_req = 2'b01;
        mem_addr_ok = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (ch_addr_ok !== 2'b01) begin
                errors++;
                $display("FAIL full_fill%0d: got aok=%b want 01", k, ch_addr_ok);
            end
            exp_ch_q.push_back(0);
            step();
        end
        @(negedge clk);
        checks++;
        if (outstanding !== 3'd4 || mem_req !== 1'b0 || ch_addr_ok !== 2'b00) begin
            errors++;
            $display("FAIL full_block: got outst=%0d req=%0b aok=%b want outst=4 req=0 aok=00", outstanding, mem_req, ch_addr_ok);
        end
        step();
        mem_data_ok = 1'b1;
        mem_rdata = 32'h4444_0000;
        @(negedge clk);
        exp = (exp_ch_q.size() > 0) ? exp_ch_q.pop_front() : -1;
        checks++;
        if (mem_req !== 1'b0 || ch_data_ok !== onehot_of(exp) || ch_rdata !== 32'h4444_0000) begin
            errors++;
            $display("FAIL full_nobypass: got req=%0b dok=%b rdata=%h want req=0 dok=%b rdata=44440000",
                     mem_req, ch_data_ok, ch_rdata, onehot_of(exp));
        end
        step();
        mem_data_ok = 1'b0;
        @(negedge clk);
        checks++;
        if (outstanding !== 3'd3 || mem_req !== 1'b1 || ch_addr_ok !== 2'b01) begin
            errors++;
            $display("FAIL full_reassert: got outst=%0d req=%0b aok=%b want outst=3 req=1 aok=01", outstanding, mem_req, ch_addr_ok);
        end
        exp_ch_q.push_back(0);
        step();
        ch_req = 2'b00;
        for (int k = 0; k < 3; k++) begin
            mem_data_ok = 1'b1;
            mem_rdata = 32'h4444_0010 + 32'(k);
            @(negedge clk);
            exp = (exp_ch_q.size() > 0) ? exp_ch_q.pop_front() : -1;
            checks++;
            if (ch_data_ok !== onehot_of(exp) || ch_rdata !== 32'h4444_0010 + 32'(k)) begin
                errors++;
                $display("FAIL full_drain%0d: got dok=%b rdata=%h want dok=%b", k, ch_data_ok, ch_rdata, onehot_of(exp));
            end
            step();
        end
        ch_req = 2'b01;
        mem_data_ok = 1'b1;
        mem_rdata = 32'h5555_0000;
        @(negedge clk);
        exp = (exp_ch_q.size() > 0) ? exp_ch_q.pop_front() : -1;
        checks++;
        if (ch_addr_ok !== 2'b01 || ch_data_ok !== onehot_of(exp) || ch_rdata !== 32'h5555_0000) begin
            errors++;
            $display("FAIL b2b_push_pop: got aok=%b dok=%b rdata=%h want aok=01 dok=%b rdata=55550000",
                     ch_addr_ok, ch_data_ok, ch_rdata, onehot_of(exp));
        end
        exp_ch_q.push_back(0);
        step();
        ch_req = 2'b00;
        mem_data_ok = 1'b0;
        @(negedge clk);
        checks++;
        if (outstanding !== 3'd1) begin
            errors++;
            $display("FAIL b2b_occupancy: got %0d want 1", outstanding);
        end
        step();
        mem_data_ok = 1'b1;
        mem_rdata = 32'h6666_0000;
        @(negedge clk);
        exp = (exp_ch_q.size() > 0) ? exp_ch_q.pop_front() : -1;
        checks++;
        if (ch_data_ok !== onehot_of(exp) || ch_rdata !== 32'h6666_0000) begin
            errors++;
            $display("FAIL b2b_last: got dok=%b rdata=%h want dok=%b", ch_data_ok, ch_rdata, onehot_of(exp));
        end
        step();
        mem_data_ok = 1'b0;
        mem_addr_ok = 1'b0;
        @(negedge clk);
        checks++;
        if (outstanding !== 3'd0 || err !== 1'b0) begin
            errors++;
            $display("FAIL full_end: got outst=%0d err=%0b want outst=0 err=0", outstanding, err);
        end
        step();
    endtask

    task automatic test_spurious();
        mem_data_ok = 1'b1;
        mem_rdata = 32'h7777_0000;
        @(negedge clk);
        checks++;
        if (ch_data_ok !== 2'b00) begin
            errors++;
            $display("FAIL spur_dok: got %b want 00", ch_data_ok);
        end
        step();
        mem_data_ok = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (err !== 1'b1) begin
                errors++;
                $display("FAIL spur_err%0d: got %0b want 1", k, err);
            end
            step();
        end
    endtask

    task automatic test_reset_midop();
        do_reset();
        @(negedge clk);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL mid_err_clear: got %0b want 0", err);
        end
        step();
        ch_addr = {32'h0000_6100, 32'h0000_6000};
        ch_req = 2'b01;
        mem_addr_ok = 1'b1;
        step();
        step();
        ch_req = 2'b00;
        mem_addr_ok = 1'b0;
        @(negedge clk);
        checks++;
        if (outstanding !== 3'd2) begin
            errors++;
            $display("FAIL mid_outstanding: got %0d want 2", outstanding);
        end
        resetn = 1'b0;
        exp_ch_q.delete();
        #1;
        checks++;
        if (outstanding !== 3'd0) begin
            errors++;
            $display("FAIL mid_async_clear: got %0d want 0", outstanding);
        end
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        step();
        mem_data_ok = 1'b1;
        @(negedge clk);
        checks++;
        if (ch_data_ok !== 2'b00) begin
            errors++;
            $display("FAIL mid_spur_dok: got %b want 00", ch_data_ok);
        end
        step();
        mem_data_ok = 1'b0;
        ch_req = 2'b11;
        mem_addr_ok = 1'b1;
        @(negedge clk);
        checks++;
        if (err !== 1'b1 || ch_addr_ok !== 2'b01) begin
            errors++;
            $display("FAIL mid_after: got err=%0b aok=%b want err=1 aok=01", err, ch_addr_ok);
        end
        step();
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        resetn = 1'b0;
        test_reset();
        test_single_read();
        test_round_robin();
        test_lock();
        test_full_and_back_to_back();
        test_spurious();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
